// File: rtl/proc_mem_sequencer.sv
// proc_mem_sequencer
// Host-side sequencer around the single-core processor. Loads a host byte
// stream into data memory (two bytes per 12-bit word), raises start_process,
// lends the data-memory port to the processor while it runs, then reads back
// a result window and streams it out as bytes (low byte, then high nibble).
// This block is the only driver of the data-memory port.
//
// Optional build macro: RUN_TIMEOUT_EN
//   defined   - 16-bit RUN cycle counter; on TIMEOUT_CYCLES without
//               end_process, sets sticky o_timeout and starts the unload.
//   undefined - no counter, o_timeout tied 0, RUN waits indefinitely.
//
// Handshakes: a byte moves on a cycle where valid and ready are both high.
// The source holds valid/data stable until then; ready never depends on
// being asked, only on the state.
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_host_valid/i_host_data/o_host_ready   host byte input
//   o_out_valid/o_out_data/i_out_ready      result byte output
//   i_proc_ar, i_proc_bus, i_proc_dm_en     processor memory request
//   i_end_process / o_start_process         processor run control
//   o_mem_addr/o_mem_wdata/o_mem_we/i_mem_rdata  data memory (1-cycle read)
//   o_busy, o_done, o_timeout      status
//   o_state                        current FSM state (debug)
module proc_mem_sequencer #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 12,
    parameter int LOAD_BASE      = 0,
    parameter int LOAD_WORDS     = 256,
    parameter int UNLOAD_BASE    = 512,
    parameter int UNLOAD_WORDS   = 256,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_host_valid,
    input  logic [7:0]        i_host_data,
    output logic              o_host_ready,
    output logic              o_out_valid,
    output logic [7:0]        o_out_data,
    input  logic              i_out_ready,
    input  logic [ADDR_W-1:0] i_proc_ar,
    input  logic [DATA_W-1:0] i_proc_bus,
    input  logic              i_proc_dm_en,
    input  logic              i_end_process,
    output logic              o_start_process,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_timeout,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_LO = 3'd1,
        S_LOAD_HI = 3'd2,
        S_RUN     = 3'd3,
        S_UNL_RD  = 3'd4,
        S_UNL_CAP = 3'd5,
        S_UNL_LO  = 3'd6,
        S_UNL_HI  = 3'd7
    } state_t;

    localparam logic [ADDR_W-1:0] LOAD_BASE_A   = ADDR_W'(LOAD_BASE);
    localparam logic [ADDR_W-1:0] UNLOAD_BASE_A = ADDR_W'(UNLOAD_BASE);
    localparam logic [ADDR_W-1:0] LOAD_LAST     = ADDR_W'(LOAD_WORDS - 1);
    localparam logic [ADDR_W-1:0] UNLOAD_LAST   = ADDR_W'(UNLOAD_WORDS - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_idx;
    logic [7:0]        r_lo;
    logic [DATA_W-1:0] r_word;
    logic              w_host_ready;
    logic              w_host_acc;
    logic              w_out_acc;
    logic              w_timeout_hit;

    assign w_host_acc = i_host_valid && w_host_ready;
    assign w_out_acc  = i_out_ready && o_out_valid;
    // IDLE decodes host_ready=1, so gate with reset to keep it low while held.
    assign o_host_ready = w_host_ready && i_rst_n;
    assign o_busy       = (r_state != S_IDLE);
    assign o_state      = r_state;

`ifdef RUN_TIMEOUT_EN
    logic [15:0] r_tcnt;
    logic        r_timeout;

    // The counter holds the number of RUN cycles already completed, so the
    // TIMEOUT_CYCLES-th RUN cycle sees TIMEOUT_CYCLES-1 and exits at its edge.
    assign w_timeout_hit = (r_state == S_RUN) && !i_end_process &&
                           (r_tcnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            // Held at zero outside RUN, which clears it on RUN entry.
            if (r_state != S_RUN) r_tcnt <= '0;
            else                  r_tcnt <= r_tcnt + 16'd1;
            if (w_timeout_hit) r_timeout <= 1'b1;
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_timeout_hit = 1'b0;
    assign o_timeout     = 1'b0;
`endif

    always_comb begin
        w_next          = r_state;
        w_host_ready    = 1'b0;
        o_out_valid     = 1'b0;
        o_out_data      = 8'h00;
        o_start_process = 1'b0;
        o_mem_addr      = '0;
        o_mem_wdata     = '0;
        o_mem_we        = 1'b0;
        o_done          = 1'b0;
        case (r_state)
            S_IDLE: begin
                // IDLE doubles as LOAD_LO for word 0.
                w_host_ready = 1'b1;
                if (w_host_acc) w_next = S_LOAD_HI;
            end
            S_LOAD_LO: begin
                w_host_ready = 1'b1;
                o_mem_addr   = LOAD_BASE_A + r_idx;
                if (w_host_acc) w_next = S_LOAD_HI;
            end
            S_LOAD_HI: begin
                w_host_ready = 1'b1;
                o_mem_addr   = LOAD_BASE_A + r_idx;
                // Only the low nibble of the high byte is part of the word.
                o_mem_wdata  = {i_host_data[3:0], r_lo};
                o_mem_we     = w_host_acc;
                if (w_host_acc) w_next = (r_idx == LOAD_LAST) ? S_RUN : S_LOAD_LO;
            end
            S_RUN: begin
                o_start_process = 1'b1;
                o_mem_addr      = i_proc_ar;
                o_mem_wdata     = i_proc_bus;
                o_mem_we        = i_proc_dm_en;
                if (i_end_process || w_timeout_hit) w_next = S_UNL_RD;
            end
            S_UNL_RD: begin
                o_mem_addr = UNLOAD_BASE_A + r_idx;
                w_next     = S_UNL_CAP;
            end
            S_UNL_CAP: begin
                w_next = S_UNL_LO;
            end
            S_UNL_LO: begin
                o_out_valid = 1'b1;
                o_out_data  = r_word[7:0];
                if (w_out_acc) w_next = S_UNL_HI;
            end
            S_UNL_HI: begin
                o_out_valid = 1'b1;
                o_out_data  = {4'b0000, r_word[11:8]};
                if (w_out_acc) begin
                    o_done = (r_idx == UNLOAD_LAST);
                    w_next = (r_idx == UNLOAD_LAST) ? S_IDLE : S_UNL_RD;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_lo    <= '0;
            r_word  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE, S_LOAD_LO: begin
                    if (w_host_acc) r_lo <= i_host_data;
                end
                S_LOAD_HI: begin
                    if (w_host_acc) r_idx <= (r_idx == LOAD_LAST) ? '0 : r_idx + 1'b1;
                end
                S_RUN: begin
                    if (w_next == S_UNL_RD) r_idx <= '0;
                end
                S_UNL_CAP: begin
                    r_word <= i_mem_rdata;
                end
                S_UNL_HI: begin
                    if (w_out_acc) r_idx <= (r_idx == UNLOAD_LAST) ? '0 : r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_mem_sequencer.sv
module tb_proc_mem_sequencer;

  logic        clk;
  logic        rst_n;
  logic        host_valid;
  logic [7:0]  host_data;
  logic        host_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [11:0] proc_ar;
  logic [11:0] proc_bus;
  logic        proc_dm_en;
  logic        end_process;
  logic        start_process;
  logic [11:0] mem_addr;
  logic [11:0] mem_wdata;
  logic        mem_we;
  logic [11:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [2:0]  state;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  logic [11:0] mem [0:4095];
  logic [7:0]  exp_q[$];

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [11:0] addr;
    logic [11:0] word;
  } load_vec_t;

  typedef struct {
    logic [11:0] ar;
    logic [11:0] bus;
    logic        en;
    logic        endp;
    logic [11:0] exp_addr;
    logic [11:0] exp_wdata;
    logic        exp_we;
  } run_vec_t;

  load_vec_t  lv[2];
  run_vec_t   rv[4];
  logic [7:0] unl_bytes[4];

  proc_mem_sequencer #(
    .ADDR_W(12), .DATA_W(12), .LOAD_BASE(0), .LOAD_WORDS(2),
    .UNLOAD_BASE(512), .UNLOAD_WORDS(2), .TIMEOUT_CYCLES(10)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_host_valid(host_valid), .i_host_data(host_data), .o_host_ready(host_ready),
    .o_out_valid(out_valid), .o_out_data(out_data), .i_out_ready(out_ready),
    .i_proc_ar(proc_ar), .i_proc_bus(proc_bus), .i_proc_dm_en(proc_dm_en),
    .i_end_process(end_process), .o_start_process(start_process),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
    .i_mem_rdata(mem_rdata), .o_busy(busy), .o_done(done),
    .o_timeout(timeout), .o_state(state)
  );

  // clock / reset and environment
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input logic exp_we,
                           input logic [11:0] exp_addr, input logic [11:0] exp_wdata);
    @(negedge clk);
    host_valid = 1'b1;
    host_data  = b;
    #1;
    check("load_host_ready", host_ready, 1);
    check("load_start_low", start_process, 0);
    check("load_mem_we", mem_we, exp_we);
    if (exp_we) begin
      check("load_mem_addr", mem_addr, exp_addr);
      check("load_mem_wdata", mem_wdata, exp_wdata);
    end
    @(posedge clk);
    #1;
    host_valid = 1'b0;
  endtask

  task automatic do_load();
    for (int i = 0; i < 2; i++) begin
      send_byte(lv[i].lo, 1'b0, 12'h000, 12'h000);
      send_byte(lv[i].hi, 1'b1, lv[i].addr, lv[i].word);
    end
    // one cycle after the last accept
    check("run_state", state, 3);
    check("run_start", start_process, 1);
    check("run_busy", busy, 1);
    for (int i = 0; i < 2; i++) check("load_mem_content", mem[lv[i].addr], lv[i].word);
  endtask

  task automatic do_unload(input logic stall);
    int d0;
    int w;
    logic [7:0] exp;
    d0 = done_cnt;
    for (int k = 0; k < 4; k++) exp_q.push_back(unl_bytes[k]);
    for (int k = 0; k < 4; k++) begin
      w = 0;
      @(negedge clk);
      while (!out_valid && w < 20) begin
        @(negedge clk);
        w++;
      end
      check("unl_valid_wait", out_valid, 1);
      exp = exp_q.pop_front();
      if (stall && k == 1) begin
        for (int s = 0; s < 5; s++) begin
          check("unl_stall_valid", out_valid, 1);
          check("unl_stall_data", out_data, exp);
          @(negedge clk);
        end
      end
      out_ready = 1'b1;
      #1;
      check("unl_data", out_data, exp);
      check("unl_done", done, (k == 3));
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
    check("unl_idle_state", state, 0);
    check("unl_idle_busy", busy, 0);
    check("unl_done_low", done, 0);
    check("unl_done_count", done_cnt - d0, 1);
  endtask

  initial begin
    lv[0] = '{lo: 8'h34, hi: 8'hF2, addr: 12'h000, word: 12'h234};
    lv[1] = '{lo: 8'hCD, hi: 8'h0A, addr: 12'h001, word: 12'hACD};
    rv[0] = '{ar: 12'h200, bus: 12'h5A5, en: 1'b1, endp: 1'b0, exp_addr: 12'h200, exp_wdata: 12'h5A5, exp_we: 1'b1};
    rv[1] = '{ar: 12'h123, bus: 12'hFFF, en: 1'b0, endp: 1'b0, exp_addr: 12'h123, exp_wdata: 12'hFFF, exp_we: 1'b0};
    rv[2] = '{ar: 12'h200, bus: 12'h9C3, en: 1'b1, endp: 1'b0, exp_addr: 12'h200, exp_wdata: 12'h9C3, exp_we: 1'b1};
    rv[3] = '{ar: 12'h201, bus: 12'h001, en: 1'b1, endp: 1'b1, exp_addr: 12'h201, exp_wdata: 12'h001, exp_we: 1'b1};
    unl_bytes[0] = 8'hC3;
    unl_bytes[1] = 8'h09;
    unl_bytes[2] = 8'h01;
    unl_bytes[3] = 8'h00;
    for (int a = 0; a < 4096; a++) mem[a] = 12'h000;

    rst_n = 1'b0; host_valid = 1'b0; host_data = 8'h00; out_ready = 1'b0;
    proc_ar = '0; proc_bus = '0; proc_dm_en = 1'b0; end_process = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    host_valid = 1'b1;
    #1;
    check("rst_host_ready", host_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_start", start_process, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    host_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_host_ready", host_ready, 1);
    check("idle_state", state, 0);

    // reset in the middle of a load
    send_byte(8'h11, 1'b0, 12'h000, 12'h000);
    send_byte(8'h22, 1'b1, 12'h000, 12'h211);
    send_byte(8'h33, 1'b0, 12'h000, 12'h000);
    check("midload_state", state, 2);
    @(negedge clk);
    #2;
    host_valid = 1'b1;
    host_data  = 8'h44;
    rst_n      = 1'b0;
    #1;
    check("midrst_host_ready", host_ready, 0);
    check("midrst_mem_we", mem_we, 0);
    check("midrst_busy", busy, 0);
    check("midrst_state", state, 0);
    host_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // load two words from address LOAD_BASE
    do_load();
    host_valid = 1'b1;
    #1;
    check("run_host_ready", host_ready, 0);

    // run passthrough, last vector has end_process with a write
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      proc_ar = rv[i].ar; proc_bus = rv[i].bus;
      proc_dm_en = rv[i].en; end_process = rv[i].endp;
      #1;
      check("pass_mem_addr", mem_addr, rv[i].exp_addr);
      check("pass_mem_wdata", mem_wdata, rv[i].exp_wdata);
      check("pass_mem_we", mem_we, rv[i].exp_we);
      check("pass_start", start_process, 1);
      check("pass_host_ready", host_ready, 0);
      @(posedge clk);
      #1;
      proc_dm_en = 1'b0; end_process = 1'b0;
      if (rv[i].endp) begin
        check("end_state", state, 4);
        check("end_start_low", start_process, 0);
        check("end_write_done", mem[12'h201], 12'h001);
        check("unl_rd_addr", mem_addr, 12'h200);
        check("unl_rd_we", mem_we, 0);
      end else begin
        check("pass_state", state, 3);
      end
    end
    host_valid = 1'b0;
    check("pass_mem_200", mem[12'h200], 12'h9C3);

    do_unload(1'b1);

    // end_process has no effect in IDLE
    @(negedge clk);
    end_process = 1'b1;
    @(posedge clk);
    #1;
    end_process = 1'b0;
    check("idle_ignore_end", state, 0);

    do_load();
`ifdef RUN_TIMEOUT_EN
    for (int i = 1; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("to_still_run", state, 3);
      check("to_not_yet", timeout, 0);
    end
    @(posedge clk);
    #1;
    check("to_exit_state", state, 4);
    check("to_flag", timeout, 1);
    check("to_start_low", start_process, 0);
    do_unload(1'b0);
    check("to_sticky", timeout, 1);
`else
    repeat (30) @(posedge clk);
    #1;
    check("no_to_still_run", state, 3);
    check("no_to_flag", timeout, 0);
    @(negedge clk);
    end_process = 1'b1;
    @(posedge clk);
    #1;
    end_process = 1'b0;
    check("no_to_exit", state, 4);
    do_unload(1'b0);
    check("no_to_flag_end", timeout, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
